// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Constants shared by the UART receive-path blocks.
//
//   UART_DATA_WIDTH  default character width in bits
//   UART_FIFO_DEPTH  default receive FIFO depth (power of two, >= 2)
//   UART_DIV_W       width of the baud divisor and character-timeout counter
//
//   Optional build macro UART_RX_FIFO_TIMEOUT_EN:
//     undefined (default) - the receive FIFO has no character-timeout logic;
//                           tout_irq_o is tied low and cfg_timeout_i ignored.
//     defined             - uart_rx_tout_cnt is built inside uart_rx_fifo and
//                           drives a sticky character-timeout interrupt.
//   The port list of uart_rx_fifo is the same in both builds.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_DIV_W      = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_tout_cnt.sv
// ----------------------------------------------------------------------------
// uart_rx_tout_cnt
//   Character-timeout counter and sticky interrupt for the receive FIFO.
//   Only instantiated when UART_RX_FIFO_TIMEOUT_EN is defined.
//
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   flush_i        FIFO flush: clears counter and interrupt
//   wr_acc_i       a character was accepted this cycle
//   pop_i          the head entry was popped this cycle
//   empty_i        FIFO is empty (counter held at 0)
//   cfg_timeout_i  timeout length in cycles, 0 disables
//   tout_irq_o     sticky timeout interrupt, cleared by pop or flush
// ----------------------------------------------------------------------------
module uart_rx_tout_cnt
    import uart_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_acc_i,
    input  logic                  pop_i,
    input  logic                  empty_i,
    input  logic [UART_DIV_W-1:0] cfg_timeout_i,
    output logic                  tout_irq_o
);

    logic [UART_DIV_W-1:0] tcnt_q;
    logic [UART_DIV_W-1:0] tcnt_d;
    logic                  irq_q;
    logic                  irq_d;
    logic                  cfg_en_s;

    assign cfg_en_s   = (cfg_timeout_i != {UART_DIV_W{1'b0}});
    assign tout_irq_o = irq_q;

    // Next-state for the idle counter and the sticky interrupt.
    always_comb begin
        tcnt_d = tcnt_q;
        irq_d  = irq_q;

        // Any FIFO activity restarts the idle measurement.
        if (flush_i || wr_acc_i || pop_i) begin
            tcnt_d = {UART_DIV_W{1'b0}};
        end else if (empty_i) begin
            tcnt_d = {UART_DIV_W{1'b0}};
        end else if (cfg_en_s && (tcnt_q != {UART_DIV_W{1'b1}})) begin
            tcnt_d = tcnt_q + {{(UART_DIV_W-1){1'b0}}, 1'b1};
        end else begin
            tcnt_d = tcnt_q;
        end

        // Clearing on pop/flush wins over a match in the same cycle.
        if (flush_i || pop_i) begin
            irq_d = 1'b0;
        end else if (cfg_en_s && (tcnt_q == cfg_timeout_i)) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_q;
        end
    end

    // Counter and interrupt state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tcnt_q <= {UART_DIV_W{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            irq_q  <= irq_d;
        end
    end

endmodule : uart_rx_tout_cnt

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Circular receive buffer between the UART receiver and the APB register
//   block. The write side is never back-pressured; a character arriving while
//   full (with no pop in the same cycle) is dropped and sets sticky ovf_o.
//   Write-to-read latency is one cycle (no bypass).
//
//   Optional macro UART_RX_FIFO_TIMEOUT_EN enables the character-timeout
//   interrupt (uart_rx_tout_cnt); otherwise tout_irq_o is tied 0.
//
//   clk_i / rst_n_i          clock, asynchronous active-low reset
//   flush_i                  synchronous flush (priority over write/pop)
//   wr_valid_i/wr_data_i     receiver character, wr_ready_o = 1 out of reset
//   rd_valid_o/rd_data_o     head entry, popped on rd_ready_i
//   cnt_o, full_o, empty_o   fill level and flags
//   cfg_thresh_i             level interrupt threshold (0 disables)
//   thresh_irq_o             cnt_o >= cfg_thresh_i (non-zero threshold)
//   ovf_o / ovf_clr_i        sticky overflow and its clear
//   cfg_timeout_i            character-timeout length (0 disables)
//   tout_irq_o               sticky character-timeout interrupt
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = UART_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  rd_ready_i,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [CNT_W-1:0]      cfg_thresh_i,
    output logic                  thresh_irq_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    input  logic [UART_DIV_W-1:0] cfg_timeout_i,
    output logic                  tout_irq_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  ready_q;
    logic                  ready_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  pop_s;
    logic                  do_write_s;
    logic                  ovf_set_s;

    assign full_s     = (count_q == CNT_W'(DEPTH));
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    assign wr_acc_s   = wr_valid_i & ready_q;
    assign pop_s      = ~empty_s & rd_ready_i;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign do_write_s = wr_acc_s & (~full_s | pop_s);
    // A flushed write is discarded rather than counted as an overflow.
    assign ovf_set_s  = wr_acc_s & full_s & ~pop_s & ~flush_i;

    assign wr_ready_o   = ready_q;
    assign rd_valid_o   = ~empty_s;
    assign rd_data_o    = mem_q[rd_ptr_q];
    assign cnt_o        = count_q;
    assign full_o       = full_s;
    assign empty_o      = empty_s;
    assign ovf_o        = ovf_q;
    // count never exceeds DEPTH, so a threshold above DEPTH never fires.
    assign thresh_irq_o = (cfg_thresh_i != {CNT_W{1'b0}}) && (count_q >= cfg_thresh_i);

    // Next-state for storage, pointers, count and overflow flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b1;

        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_write_s) begin
                mem_d[wr_ptr_q] = wr_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({do_write_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Clear has priority over a simultaneous overflow.
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_tout_cnt u_tout_cnt (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .wr_acc_i      (wr_acc_s),
        .pop_i         (pop_s),
        .empty_i       (empty_s),
        .cfg_timeout_i (cfg_timeout_i),
        .tout_irq_o    (tout_irq_o)
    );
`else
    logic tout_unused_s;
    assign tout_unused_s = ^cfg_timeout_i;
    assign tout_irq_o    = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic [4:0]  cfg_thresh;
    logic        thresh_irq;
    logic        ovf;
    logic        ovf_clr;
    logic [15:0] cfg_timeout;
    logic        tout_irq;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .rd_ready_i    (rd_ready),
        .cnt_o         (cnt),
        .full_o        (full),
        .empty_o       (empty),
        .cfg_thresh_i  (cfg_thresh),
        .thresh_irq_o  (thresh_irq),
        .ovf_o         (ovf),
        .ovf_clr_i     (ovf_clr),
        .cfg_timeout_i (cfg_timeout),
        .tout_irq_o    (tout_irq)
    );

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        rd_ready = 1'b0; cfg_thresh = 5'd0; ovf_clr = 1'b0; cfg_timeout = 16'd0;
        step(); step();
        nchk++; if (cnt !== 5'd0) begin nerr++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        nchk++; if ({empty, full, rd_valid} !== 3'b100) begin nerr++; $display("FAIL reset_flags: got e/f/v=%b expected 100", {empty, full, rd_valid}); end
        nchk++; if ({ovf, tout_irq, thresh_irq} !== 3'b000) begin nerr++; $display("FAIL reset_irq: got ovf/tout/thr=%b expected 000", {ovf, tout_irq, thresh_irq}); end
        nchk++; if (rd_data !== 8'h00) begin nerr++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        rst_n = 1'b1;
        step(); step();
        nchk++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL wr_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_single();
        put(8'hA5);
        nchk++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin nerr++; $display("FAIL single_rd: got v=%b d=%h expected v=1 d=a5", rd_valid, rd_data); end
        nchk++; if (cnt !== 5'd1 || empty !== 1'b0) begin nerr++; $display("FAIL single_cnt: got cnt=%0d empty=%b expected 1/0", cnt, empty); end
        pop_one();
        nchk++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin nerr++; $display("FAIL single_pop: got empty=%b v=%b expected 1/0", empty, rd_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) put(8'(i));
        nchk++; if (full !== 1'b1 || cnt !== 5'd16) begin nerr++; $display("FAIL ovf_fill: got full=%b cnt=%0d expected 1/16", full, cnt); end
        put(8'h55);
        nchk++; if (ovf !== 1'b1 || cnt !== 5'd16) begin nerr++; $display("FAIL ovf_set: got ovf=%b cnt=%0d expected 1/16", ovf, cnt); end
        for (int i = 0; i < 16; i++) begin
            nchk++; if (rd_data !== 8'(i)) begin nerr++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, rd_data, 8'(i)); end
            pop_one();
        end
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL ovf_drain: got empty=%b expected 1", empty); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        nchk++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
    endtask

    task automatic test_full_pop_write();
        for (int i = 0; i < 16; i++) put(8'h10 + 8'(i));
        wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        nchk++; if (ovf !== 1'b0 || cnt !== 5'd16) begin nerr++; $display("FAIL fullpop: got ovf=%b cnt=%0d expected 0/16", ovf, cnt); end
        for (int i = 1; i < 16; i++) begin
            nchk++; if (rd_data !== 8'h10 + 8'(i)) begin nerr++; $display("FAIL fullpop_order[%0d]: got %h expected %h", i, rd_data, 8'h10 + 8'(i)); end
            pop_one();
        end
        nchk++; if (rd_data !== 8'h77) begin nerr++; $display("FAIL fullpop_last: got %h expected 77", rd_data); end
        pop_one();
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL fullpop_drain: got empty=%b expected 1", empty); end
    endtask

    task automatic test_thresh();
        cfg_thresh = 5'd4;
        for (int i = 0; i < 3; i++) put(8'h20 + 8'(i));
        nchk++; if (thresh_irq !== 1'b0) begin nerr++; $display("FAIL thr_3: got %b expected 0", thresh_irq); end
        put(8'h23);
        nchk++; if (thresh_irq !== 1'b1) begin nerr++; $display("FAIL thr_4: got %b expected 1", thresh_irq); end
        pop_one();
        nchk++; if (thresh_irq !== 1'b0) begin nerr++; $display("FAIL thr_pop: got %b expected 0", thresh_irq); end
        cfg_thresh = 5'd0;
        for (int i = 0; i < 13; i++) put(8'h30 + 8'(i));
        nchk++; if (thresh_irq !== 1'b0 || full !== 1'b1) begin nerr++; $display("FAIL thr_zero: got irq=%b full=%b expected 0/1", thresh_irq, full); end
        cfg_thresh = 5'd16; #1;
        nchk++; if (thresh_irq !== 1'b1) begin nerr++; $display("FAIL thr_16: got %b expected 1", thresh_irq); end
        cfg_thresh = 5'd17; #1;
        nchk++; if (thresh_irq !== 1'b0) begin nerr++; $display("FAIL thr_17: got %b expected 0", thresh_irq); end
        cfg_thresh = 5'd0;
    endtask

    task automatic test_flush();
        put(8'h99);
        nchk++; if (ovf !== 1'b1) begin nerr++; $display("FAIL flush_preovf: got %b expected 1", ovf); end
        flush = 1'b1; step(); flush = 1'b0;
        nchk++; if (cnt !== 5'd0 || ovf !== 1'b1) begin nerr++; $display("FAIL flush_full: got cnt=%0d ovf=%b expected 0/1", cnt, ovf); end
        for (int i = 0; i < 5; i++) put(8'h40 + 8'(i));
        nchk++; if (cnt !== 5'd5) begin nerr++; $display("FAIL flush_fill5: got %0d expected 5", cnt); end
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        nchk++; if (cnt !== 5'd0 || empty !== 1'b1 || ovf !== 1'b1) begin nerr++; $display("FAIL flush_wr: got cnt=%0d empty=%b ovf=%b expected 0/1/1", cnt, empty, ovf); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        put(8'hC3);
        nchk++; if (cnt !== 5'd1 || rd_data !== 8'hC3) begin nerr++; $display("FAIL flush_after: got cnt=%0d d=%h expected 1/c3", cnt, rd_data); end
        pop_one();
    endtask

    task automatic test_timeout();
        int rise;
        int exp_rise;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        exp_rise = 11;
`else
        exp_rise = 0;
`endif
        cfg_timeout = 16'd10;
        put(8'h61);
        rise = 0;
        for (int k = 1; k <= 20; k++) begin
            if (rise == 0 && tout_irq === 1'b1) rise = k - 1;
            step();
        end
        if (rise == 0 && tout_irq === 1'b1) rise = 20;
        nchk++; if (rise !== exp_rise) begin nerr++; $display("FAIL tout_rise: got cycle %0d expected %0d", rise, exp_rise); end
        pop_one();
        nchk++; if (tout_irq !== 1'b0) begin nerr++; $display("FAIL tout_clr: got %b expected 0", tout_irq); end
        cfg_timeout = 16'd0;
        put(8'h62);
        rise = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (tout_irq === 1'b1) rise = k;
        end
        nchk++; if (rise !== 0) begin nerr++; $display("FAIL tout_dis: got rise at %0d expected none", rise); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop_write();
        test_thresh();
        test_flush();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule : tb_uart_rx_fifo
